// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the team FIFO: issues rd_en, captures the registered
// dout/valid pair into a 3-entry skid buffer and re-presents it as a valid/ready stream.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_valid,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  err_unsolicited
);

  localparam int DEPTH  = 3;
  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] buf_reg [DEPTH];
  logic [1:0]            head_reg, head_next;
  logic [1:0]            tail_reg, tail_next;
  logic [1:0]            occ_reg, occ_next;
  logic                  inflight_reg;
  logic [BEAT_W-1:0]     beat_reg, beat_next;
  logic                  err_reg, err_next;

  logic capture;
  logic drop;
  logic handshake;
  logic [2:0] committed;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Occupancy plus the read already on the wire must leave room for the word
  // that this read will return, so the buffer can never overflow.
  assign committed  = {1'b0, occ_reg} + {2'b00, inflight_reg};
  assign fifo_rd_en = ~rst & ~fifo_empty & (committed < 3'd3);

  assign capture   = fifo_valid & inflight_reg;
  assign drop      = fifo_valid & ~inflight_reg;
  assign m_valid   = (occ_reg != 2'd0);
  assign handshake = m_valid & m_ready;
  assign m_last    = m_valid & (beat_reg == BEAT_MAX);
  assign err_unsolicited = err_reg;

  always_comb begin
    m_data = buf_reg[0];
    case (head_reg)
      2'd1:    m_data = buf_reg[1];
      2'd2:    m_data = buf_reg[2];
      default: m_data = buf_reg[0];
    endcase
  end

  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    occ_next  = occ_reg;
    beat_next = beat_reg;
    err_next  = err_reg | drop;

    if (capture) begin
      tail_next = ptr_inc(tail_reg);
    end
    if (handshake) begin
      head_next = ptr_inc(head_reg);
      beat_next = (beat_reg == BEAT_MAX) ? '0 : beat_reg + BEAT_W'(1);
    end

    case ({capture, handshake})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg     <= 2'd0;
      tail_reg     <= 2'd0;
      occ_reg      <= 2'd0;
      inflight_reg <= 1'b0;
      beat_reg     <= '0;
      err_reg      <= 1'b0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      occ_reg      <= occ_next;
      inflight_reg <= fifo_rd_en;
      beat_reg     <= beat_next;
      err_reg      <= err_next;
    end
  end

  // Each entry is its own register so m_data comes straight from flops.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          buf_reg[gi] <= '0;
        end else if (capture && (tail_reg == 2'(gi))) begin
          buf_reg[gi] <= fifo_dout;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a behavioural FIFO feeds the DUT and a
// scoreboard queue holds the expected data/last for each pushed word.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_valid;
  logic          fifo_valid_model = 1'b0;
  logic          inject;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          err_unsolicited;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_dout      (fifo_dout),
    .fifo_valid     (fifo_valid),
    .fifo_empty     (fifo_empty),
    .fifo_rd_en     (fifo_rd_en),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .err_unsolicited(err_unsolicited)
  );

  // Behavioural FIFO: registered dout/valid one cycle after rd_en, cleared by rst.
  logic [DW-1:0] mem [0:255];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign fifo_empty = (push_cnt == pop_cnt);
  assign fifo_valid = fifo_valid_model | inject;

  always @(posedge clk) begin
    if (rst) begin
      fifo_valid_model <= 1'b0;
      pop_cnt          <= push_cnt;
    end else begin
      fifo_valid_model <= fifo_rd_en;
      if (fifo_rd_en) begin
        fifo_dout <= mem[pop_cnt];
        pop_cnt   <= pop_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int errors   = 0;
  int cycle    = 0;
  int rd_total = 0;
  int hs_total = 0;
  int first_hs = -1;
  int last_hs  = -1;
  int push_idx = 0;
  logic          samp_rd;
  logic          samp_valid;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    exp_t e;
    mem[push_cnt] = v;
    push_cnt++;
    e.data = v;
    e.last = ((push_idx % PL) == (PL - 1));
    exp_q.push_back(e);
    push_idx++;
  endtask

  // One clock: sample at the falling edge, return 1 time unit after the rising edge.
  task automatic cyc();
    @(negedge clk);
    samp_rd    = fifo_rd_en;
    samp_valid = m_valid;
    chk("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
    if (fifo_rd_en) rd_total++;
    if (rst) begin
      chk("rd_en_in_reset", 32'(fifo_rd_en), 32'd0);
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("valid_with_nothing_expected", 32'(m_valid), 32'd0);
        end else begin
          chk("m_data", 32'(m_data), 32'(exp_q[0].data));
          chk("m_last", 32'(m_last), 32'(exp_q[0].last));
          if (m_ready) begin
            void'(exp_q.pop_front());
            $display("beat %0d cycle %0d data=%02h last=%0b", hs_total, cycle, m_data, m_last);
            hs_total++;
            if (first_hs < 0) first_hs = cycle;
            last_hs = cycle;
          end
        end
      end else begin
        chk("m_last_idle", 32'(m_last), 32'd0);
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
    end
    cycle++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      cyc();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    repeat (3) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    exp_q.delete();
    push_idx = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int h0;
    logic [5:0] rd_pat;
    logic [5:0] v_pat;

    // Reset with a word in the FIFO and a stray valid: neither may leak out.
    rst     = 1'b1;
    m_ready = 1'b0;
    inject  = 1'b1;
    push(8'h77);
    cyc();
    cyc();
    rst    = 1'b0;
    inject = 1'b0;
    exp_q.delete();
    push_idx = 0;
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_m_last", 32'(m_last), 32'd0);
    chk("reset_m_data", 32'(m_data), 32'd0);
    chk("reset_err", 32'(err_unsolicited), 32'd0);
    chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);

    // Single word: one read, output exactly two cycles later for one cycle.
    m_ready = 1'b1;
    push(8'hA5);
    rd_pat = '0;
    v_pat  = '0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      rd_pat[i] = samp_rd;
      v_pat[i]  = samp_valid;
    end
    chk("single_rd_pattern", 32'(rd_pat), 32'h01);
    chk("single_valid_pattern", 32'(v_pat), 32'h04);

    // Streaming: 8 beats back to back, last on 0x04 and 0x08.
    do_reset();
    h0 = hs_total;
    first_hs = -1;
    for (int i = 1; i <= 8; i++) push(8'(i));
    drain("stream_drained");
    chk("stream_beats", 32'(hs_total - h0), 32'd8);
    chk("stream_no_bubbles", 32'(last_hs - first_hs), 32'd7);

    // Backpressure: only three reads may be issued while stalled.
    m_ready = 1'b0;
    r0 = rd_total;
    h0 = hs_total;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    repeat (8) cyc();
    chk("bp_reads_issued", 32'(rd_total - r0), 32'd3);
    chk("bp_m_valid", 32'(m_valid), 32'd1);
    chk("bp_m_data", 32'(m_data), 32'h10);
    m_ready = 1'b1;
    drain("bp_drained");
    chk("bp_beats", 32'(hs_total - h0), 32'd8);

    // Alternating stall over 16 words.
    h0 = hs_total;
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
      m_ready = ~m_ready;
      cyc();
    end
    chk("alt_drained", 32'(exp_q.size()), 32'd0);
    chk("alt_beats", 32'(hs_total - h0), 32'd16);
    m_ready = 1'b1;
    repeat (3) cyc();

    // Reset mid-stream with two words buffered and one read in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
    repeat (3) cyc();
    chk("mid_valid_before_rst", 32'(m_valid), 32'd1);
    do_reset();
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_m_last", 32'(m_last), 32'd0);
    push(8'h3C);
    m_ready = 1'b1;
    drain("mid_rst_drained");

    // Unsolicited valid: flag set, nothing buffered, flag sticky until reset.
    chk("unsol_err_before", 32'(err_unsolicited), 32'd0);
    inject = 1'b1;
    cyc();
    inject = 1'b0;
    chk("unsol_err_set", 32'(err_unsolicited), 32'd1);
    chk("unsol_no_word", 32'(m_valid), 32'd0);
    repeat (5) cyc();
    chk("unsol_err_sticky", 32'(err_unsolicited), 32'd1);
    push(8'h5A);
    drain("unsol_traffic_drained");
    chk("unsol_err_after_traffic", 32'(err_unsolicited), 32'd1);
    do_reset();
    chk("unsol_err_cleared", 32'(err_unsolicited), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer stage for the team's `fifo` block.
- Drives the FIFO's `rd_en` and captures the registered `dout`/`valid` pair, which arrives one cycle after `rd_en`.
- Re-presents the words as a valid/ready stream with backpressure, a packet-boundary `last` flag and a sticky protocol-error flag.
- Decouples downstream stall logic from the FIFO's fixed read latency.
- Sustains one word per cycle with no combinational path from `m_ready` to `fifo_rd_en`.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and stream data.
- PKT_LEN, 4, beats per packet; `m_last` marks beat PKT_LEN-1. Legal range is ≥1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset (drive the FIFO's rst_n with ~rst)
- fifo_dout  in  DATA_WIDTH  FIFO registered read data
- fifo_valid  in  1  FIFO read-data valid, one cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read request
- m_data  out  DATA_WIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  downstream ready
- m_last  out  1  last beat of packet
- err_unsolicited  out  1  sticky: fifo_valid seen with no read outstanding

Behaviour:

Internal state:
- 3-entry circular skid buffer: head/tail pointers 0..2 wrapping 2→0, occupancy `occ` 0..3.
- `inflight` bit: a read was issued last cycle.
- Beat counter 0..PKT_LEN-1, width clog2(PKT_LEN), minimum 1 bit.

Read issue:
- fifo_rd_en = ~rst & ~fifo_empty & ((occ + inflight) < 3).
- The condition is combinational from registered state plus fifo_empty only.
- inflight <= fifo_rd_en each cycle; reset value 0.

Capture:
- When fifo_valid & inflight: write fifo_dout at tail, advance tail.
- When fifo_valid & ~inflight: discard the word and set err_unsolicited; it stays set until rst.

Output:
- m_valid = (occ != 0); m_data = entry at head, taken directly from buffer registers.
- Handshake on m_valid & m_ready: advance head, decrement occ.
- Simultaneous capture and handshake: occ unchanged, both pointers advance.
- m_data and m_valid are held stable while m_valid & ~m_ready.

Latency:
- rd_en in cycle t → captured at end of t+1 → m_valid earliest in t+2.
- Steady state with m_ready=1: one beat per cycle.

Packet flag:
- m_last = m_valid & (beat_cnt == PKT_LEN-1).
- beat_cnt increments on each handshake and wraps to 0 after PKT_LEN-1.
- PKT_LEN=1 gives m_last=m_valid.

Overflow:
- occ + inflight ≤ 3 by construction, so the buffer never overflows.
- Verification asserts occ never exceeds 3 and fifo_rd_en is never high while fifo_empty.

Reset:
- Values: occ=0, head=tail=0, inflight=0, beat_cnt=0, err_unsolicited=0.
- Outputs: m_valid=0, m_last=0, fifo_rd_en=0, m_data=0.
- Reset mid-operation drops buffered words and any in-flight read.
- fifo_valid sampled while rst=1 is ignored and does not set the error.
- The FIFO is reset in the same cycle, so no stale word follows.

Test Plan:
- Single word: push 0xA5 into the empty FIFO, m_ready=1 → fifo_rd_en pulses once; m_valid=1 with m_data=0xA5 exactly 2 cycles later for 1 cycle; m_last=0.
- Streaming: push 0x01..0x08, m_ready=1 → 8 consecutive m_valid cycles, data in order 0x01..0x08; m_last on 0x04 and 0x08 (PKT_LEN=4); no bubbles after the first beat.
- Backpressure: push 0x10..0x17, m_ready=0 → exactly 3 reads issued, occ=3; m_data holds 0x10. Release m_ready → 0x10..0x17 delivered in order with nothing lost or duplicated.
- Alternating stall: m_ready toggles 1/0 over 16 words → every word is delivered once in order; m_data is stable while stalled; fifo_rd_en never asserted with fifo_empty=1.
- Reset mid-stream: assert rst for 1 cycle with occ=2 and inflight=1 → next cycle m_valid=0, beat_cnt=0; new word 0x3C after reset → appears first, with m_last=0.
- Unsolicited valid: force fifo_valid=1 with no preceding rd_en → err_unsolicited=1 and occ unchanged; flag stays set until rst.
